move_cmd_exec: RTL and testbench
================================

Name: move_cmd_exec

Overview:
- Consumer end of the 16-bit command / cmd_rdy / clr_cmd_rdy / send_resp interface that feeds movement commands into the robot.
- Accepts one command at a time, acknowledges it, and runs it:
  - calibrate, or
  - turn to a heading, ramp speed up, count square crossings, ramp down.
- Pulses send_resp when done, so the command multiplexer and UART response path can advance.
- Sits between the command mux and the heading/PID and motor-speed path.

Parameters:
MAX_SPD, 10'h2A0, saturation value of frwrd_spd
SPD_INC, 10'h008, frwrd_spd increment per heading_rdy while ramping up
SPD_DEC, 10'h020, frwrd_spd decrement per heading_rdy while ramping down
ERR_THRESH, 12'd48, |error| below this ends TURN

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd  in  16  [15:12] opcode, [11:4] heading, [3:0] squares
cmd_rdy  in  1  command valid, level, held until clr_cmd_rdy
clr_cmd_rdy  out  1  one-cycle acknowledge; command latched this cycle
send_resp  out  1  one-cycle pulse: command finished
cal_done  in  1  gyro calibration complete pulse
strt_cal  out  1  one-cycle calibration start pulse
error  in  12  signed heading error from PID
heading_rdy  in  1  new heading sample strobe, ramp timebase
cntrIR  in  1  center line sensor, async-ish level
desired_heading  out  12  heading target to PID
frwrd_spd  out  10  forward speed to PID
moving  out  1  high while turning/driving
fanfare_go  out  1  one-cycle pulse on move-with-fanfare completion

Behaviour:
- Reset (rst high at a clk edge): state IDLE.
  - All outputs 0.
  - Latched cmd 0, line count 0, cntrIR edge-history flops 0.
  - A reset mid-move abandons the command and no send_resp is issued.
- Opcodes:
  - 4'h0 calibrate.
  - 4'h2 move.
  - 4'h3 move with fanfare.
  - Any other opcode is illegal.
- IDLE:
  - On cmd_rdy: clr_cmd_rdy=1 that same cycle, cmd latched.
  - Opcode 0: strt_cal=1 next cycle, go to CAL.
  - Opcode 2/3:
    - desired_heading = (heading==0) ? 12'h000 : {heading,4'hF}.
    - moving=1, line count cleared, go to TURN.
  - Illegal opcode: send_resp=1 next cycle, stay IDLE, no motion.
- cmd_rdy while not IDLE: ignored; clr_cmd_rdy stays 0 until back in IDLE.
- CAL: on cal_done, send_resp=1 next cycle, go to IDLE.
- TURN:
  - frwrd_spd held 0.
  - When |error| < ERR_THRESH:
    - If squares==0: moving=0, send_resp pulse, go to IDLE.
    - Else go to RAMP_UP.
  - |error| uses 12-bit magnitude; -2048 saturates to 2047.
- RAMP_UP:
  - Each heading_rdy: frwrd_spd = min(frwrd_spd+SPD_INC, MAX_SPD), with no 10-bit wrap.
  - Rising edges of cntrIR are counted, after a 2-flop synchronizer plus an edge flop, so latency is 3 clk.
  - When count == {squares,1'b0}, go to RAMP_DOWN; fanfare_go=1 on that transition if opcode==3.
- RAMP_DOWN:
  - Each heading_rdy: frwrd_spd = max(frwrd_spd-SPD_DEC, 0), no underflow.
  - When frwrd_spd==0: moving=0, send_resp=1 for one cycle, go to IDLE.
  - Further cntrIR edges are ignored.
- Simultaneous events:
  - heading_rdy and the count reaching its target in the same cycle: the increment is applied, then the state changes.
  - At most one of clr_cmd_rdy / send_resp is high per cycle.
- Line counter is 5 bits, max target 30; it cannot wrap before the target is reached.
- desired_heading holds its value after completion until the next move command.

Decomposition:
- Package move_cmd_pkg:
  - opcode localparams OP_CAL=4'h0, OP_MOVE=4'h2, OP_FANFARE=4'h3.
  - state_t enum {IDLE, CAL, TURN, RAMP_UP, RAMP_DOWN}.
  - Field slice constants for cmd.
- Sub-module line_counter:
  - cntrIR synchronizer, rising-edge detect, 5-bit counter with clear and enable.
  - Output cnt[4:0].

Test Plan:
- cmd=16'h0000, cmd_rdy held → clr_cmd_rdy pulse, strt_cal pulse next cycle; cal_done at cycle 20 → send_resp exactly one cycle later, moving stays 0.
- cmd=16'h2002, error=12'd10 → desired_heading=12'h000, TURN exits immediately. frwrd_spd steps 8,16,… per heading_rdy up to 0x2A0. After 4 cntrIR rising edges it decrements by 0x20 to 0; then send_resp, moving=0, fanfare_go never set.
- cmd=16'h37F1, error starts at 12'h400 and later drops to 12'd47 → desired_heading=12'h7FF, no speed until |error|<48. After 2 edges fanfare_go pulses once; send_resp follows when speed reaches 0.
- cmd=16'h2BF0 with |error|<48 → TURN completes, no ramp, send_resp, frwrd_spd remains 0.
- cmd=16'h9001 → clr_cmd_rdy then send_resp next cycle, moving never asserted. Second cmd_rdy raised during a move → no clr_cmd_rdy until IDLE.
- rst asserted during RAMP_UP with frwrd_spd=0x100 → next cycle all outputs 0, state IDLE, no send_resp; a new command is accepted afterwards.

Source files
------------

// File: rtl/move_cmd_pkg.sv
// Shared opcodes, cmd field positions, ramp constants and FSM state type for the
// movement command executor.
package move_cmd_pkg;

  localparam logic [3:0] OP_CAL     = 4'h0;
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned HDG_MSB = 11;
  localparam int unsigned HDG_LSB = 4;
  localparam int unsigned SQ_MSB  = 3;
  localparam int unsigned SQ_LSB  = 0;

  localparam logic [9:0]  MAX_SPD    = 10'h2A0;
  localparam logic [9:0]  SPD_INC    = 10'h008;
  localparam logic [9:0]  SPD_DEC    = 10'h020;
  localparam logic [11:0] ERR_THRESH = 12'd48;

  typedef enum logic [2:0] {IDLE, CAL, TURN, RAMP_UP, RAMP_DOWN} state_t;

  // Magnitude of a signed 12-bit error; -2048 has no positive twin, so saturate.
  function automatic logic [11:0] err_mag(input logic [11:0] e);
    if (e == 12'h800) return 12'h7FF;
    else if (e[11]) return 12'h000 - e;
    else return e;
  endfunction

endpackage

// File: rtl/move_cmd_exec_line_counter.sv
// Counts rising edges of the centre line sensor after a two-flop synchronizer.
module line_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       cntrIR,
  input  logic       clr,
  input  logic       en,
  output logic [4:0] cnt
);

  logic       sync1_q, sync2_q, prev_q;
  logic [4:0] cnt_q, cnt_d;
  logic       rise;

  assign rise = sync2_q & ~prev_q;
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = 5'd0;
    else if (en && rise) cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      sync1_q <= cntrIR;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/move_cmd_exec.sv
// Accepts one movement/calibration command at a time, runs it, and pulses send_resp
// when it is finished.
module move_cmd_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic        cal_done,
  output logic        strt_cal,
  input  logic [11:0] error,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic [11:0] desired_heading,
  output logic [9:0]  frwrd_spd,
  output logic        moving,
  output logic        fanfare_go
);
  import move_cmd_pkg::*;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  sq_q, sq_d;
  logic [11:0] dh_q, dh_d;
  logic [9:0]  spd_q, spd_d;
  logic        strt_q, strt_d;
  logic        resp_q, resp_d;
  logic        fan_q, fan_d;
  logic        accept, cnt_clr, cnt_en;
  logic [4:0]  cnt;
  logic [10:0] spd_inc;
  logic [3:0]  op_in;
  logic [7:0]  hdg_in;

  line_counter u_line_counter (
    .clk    (clk),
    .rst    (rst),
    .cntrIR (cntrIR),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .cnt    (cnt)
  );

  assign op_in   = cmd[OP_MSB:OP_LSB];
  assign hdg_in  = cmd[HDG_MSB:HDG_LSB];
  assign spd_inc = {1'b0, spd_q} + {1'b0, SPD_INC};
  assign cnt_en  = (state_q == RAMP_UP);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sq_d    = sq_q;
    dh_d    = dh_q;
    spd_d   = spd_q;
    strt_d  = 1'b0;
    resp_d  = 1'b0;
    fan_d   = 1'b0;
    accept  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Hold off the acknowledge while a response pulse is out.
        if (cmd_rdy && !resp_q) begin
          accept = 1'b1;
          op_d   = op_in;
          sq_d   = cmd[SQ_MSB:SQ_LSB];
          if (op_in == OP_CAL) begin
            strt_d  = 1'b1;
            state_d = CAL;
          end else if (op_in == OP_MOVE || op_in == OP_FANFARE) begin
            dh_d    = (hdg_in == 8'h00) ? 12'h000 : {hdg_in, 4'hF};
            cnt_clr = 1'b1;
            state_d = TURN;
          end else begin
            resp_d = 1'b1;
          end
        end
      end
      CAL: begin
        if (cal_done) begin
          resp_d  = 1'b1;
          state_d = IDLE;
        end
      end
      TURN: begin
        spd_d = 10'd0;
        if (err_mag(error) < ERR_THRESH) begin
          if (sq_q == 4'd0) begin
            resp_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        if (heading_rdy) spd_d = (spd_inc > {1'b0, MAX_SPD}) ? MAX_SPD : spd_inc[9:0];
        if (cnt == {sq_q, 1'b0}) begin
          state_d = RAMP_DOWN;
          fan_d   = (op_q == OP_FANFARE);
        end
      end
      RAMP_DOWN: begin
        if (spd_q == 10'd0) begin
          resp_d  = 1'b1;
          state_d = IDLE;
        end else if (heading_rdy) begin
          spd_d = (spd_q > SPD_DEC) ? spd_q - SPD_DEC : 10'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      sq_q    <= 4'd0;
      dh_q    <= 12'd0;
      spd_q   <= 10'd0;
      strt_q  <= 1'b0;
      resp_q  <= 1'b0;
      fan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sq_q    <= sq_d;
      dh_q    <= dh_d;
      spd_q   <= spd_d;
      strt_q  <= strt_d;
      resp_q  <= resp_d;
      fan_q   <= fan_d;
    end
  end

  assign clr_cmd_rdy     = accept & ~rst;
  assign send_resp       = resp_q;
  assign strt_cal        = strt_q;
  assign fanfare_go      = fan_q;
  assign desired_heading = dh_q;
  assign frwrd_spd       = spd_q;
  assign moving          = (state_q == TURN) || (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: tb/tb_move_cmd_exec.sv
// Randomized bench for move_cmd_exec with a cycle-level behavioural model and
// literal spot checks per directed scenario.
module tb_move_cmd_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = 16'h0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy, send_resp, strt_cal, moving, fanfare_go;
  logic        cal_done = 1'b0;
  logic [11:0] error = 12'h0;
  logic        heading_rdy = 1'b0;
  logic        cntrIR = 1'b0;
  logic [11:0] desired_heading;
  logic [9:0]  frwrd_spd;

  always #5 clk = ~clk;

  move_cmd_exec dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (cmd),
    .cmd_rdy         (cmd_rdy),
    .clr_cmd_rdy     (clr_cmd_rdy),
    .send_resp       (send_resp),
    .cal_done        (cal_done),
    .strt_cal        (strt_cal),
    .error           (error),
    .heading_rdy     (heading_rdy),
    .cntrIR          (cntrIR),
    .desired_heading (desired_heading),
    .frwrd_spd       (frwrd_spd),
    .moving          (moving),
    .fanfare_go      (fanfare_go)
  );

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 calibrating, 2 turning, 3 speeding up, 4 slowing down.
  int          m_mode, m_dh, m_spd, m_cnt;
  logic [15:0] m_cmd;
  bit          m_strt, m_resp, m_fan;
  bit          irq[$];  // cntrIR seen at the last three edges, oldest first

  int hr_pct = 50;
  bit ir_en = 0;
  bit err_rand = 0;
  int cal_pct = 0;
  int ir_run = 0;
  int seen_resp, seen_strt, seen_fan, seen_mov, peak_spd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_mode = 0; m_dh = 0; m_spd = 0; m_cnt = 0; m_cmd = 16'h0;
    m_strt = 0; m_resp = 0; m_fan = 0;
    irq = '{0, 0, 0};
  endfunction

  function automatic void model_next(input bit acc);
    int op, hd, sq, mag;
    bit rise;
    if (rst) begin
      m_reset();
      return;
    end
    rise = irq[1] && !irq[0];
    m_strt = 0; m_resp = 0; m_fan = 0;
    op = m_cmd[15:12];
    sq = m_cmd[3:0];
    mag = $signed(error);
    if (mag < 0) mag = -mag;
    if (mag > 2047) mag = 2047;
    case (m_mode)
      0: if (acc) begin
        m_cmd = cmd;
        op = cmd[15:12];
        hd = cmd[11:4];
        if (op == 0) begin
          m_strt = 1; m_mode = 1;
        end else if (op == 2 || op == 3) begin
          m_dh = (hd == 0) ? 0 : hd * 16 + 15;
          m_cnt = 0; m_mode = 2;
        end else m_resp = 1;
      end
      1: if (cal_done) begin m_resp = 1; m_mode = 0; end
      2: if (mag < 48) begin
        if (sq == 0) begin m_resp = 1; m_mode = 0; end
        else m_mode = 3;
      end
      3: begin
        if (heading_rdy) m_spd = (m_spd + 8 > 672) ? 672 : m_spd + 8;
        if (m_cnt == 2 * sq) begin m_mode = 4; m_fan = (op == 3); end
        if (rise) m_cnt++;
      end
      4: if (m_spd == 0) begin m_resp = 1; m_mode = 0; end
         else if (heading_rdy) m_spd = (m_spd < 32) ? 0 : m_spd - 32;
      default: m_mode = 0;
    endcase
    irq.push_back(cntrIR);
    void'(irq.pop_front());
  endfunction

  task automatic step();
    bit e_clr;
    int e;
    @(negedge clk);
    heading_rdy = ($urandom_range(99) < hr_pct);
    if (ir_en) begin
      if (ir_run == 0) begin
        cntrIR = ~cntrIR;
        ir_run = $urandom_range(6, 2);
      end else ir_run--;
    end else cntrIR = 1'b0;
    if (err_rand) begin
      if ($urandom_range(3) == 0) e = $urandom_range(4095);
      else e = int'($urandom_range(100)) - 50;
      error = 12'(e);
    end
    if (cal_pct > 0) cal_done = ($urandom_range(99) < cal_pct);
    #1;
    e_clr = !rst && m_mode == 0 && cmd_rdy && !m_resp;
    chk("clr_cmd_rdy", clr_cmd_rdy, e_clr);
    chk("send_resp", send_resp, m_resp);
    chk("strt_cal", strt_cal, m_strt);
    chk("fanfare_go", fanfare_go, m_fan);
    chk("moving", moving, (m_mode >= 2));
    chk("desired_heading", desired_heading, m_dh);
    chk("frwrd_spd", frwrd_spd, m_spd);
    chk("clr_resp_excl", clr_cmd_rdy & send_resp, 1'b0);
    if (send_resp) seen_resp++;
    if (strt_cal) seen_strt++;
    if (fanfare_go) seen_fan++;
    if (moving) seen_mov++;
    if (int'(frwrd_spd) > peak_spd) peak_spd = frwrd_spd;
    model_next(e_clr);
    @(posedge clk);
    #1;
    if (e_clr) cmd_rdy = 1'b0;
  endtask

  task automatic clear_seen();
    seen_resp = 0; seen_strt = 0; seen_fan = 0; seen_mov = 0; peak_spd = 0;
  endtask

  task automatic issue(input logic [15:0] c);
    cmd = c;
    cmd_rdy = 1'b1;
  endtask

  task automatic run_done(input string name, input int budget);
    int n = 0;
    step();
    while ((m_mode != 0 || cmd_rdy) && n < budget) begin
      step();
      n++;
    end
    if (m_mode != 0 || cmd_rdy) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, budget);
    end
    repeat (3) step();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] errs[4];
    int op;
    errs = '{12'h400, 12'h800, 12'hFD0, 12'd48};
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_spd", frwrd_spd, 10'd0);
    chk("reset_moving", moving, 1'b0);
    chk("reset_dh", desired_heading, 12'h000);
    chk("reset_resp", send_resp, 1'b0);

    // Calibrate, cal_done around cycle 20.
    clear_seen();
    issue(16'h0000);
    repeat (19) step();
    cal_done = 1'b1;
    step();
    cal_done = 1'b0;
    run_done("cal", 100);
    chk("s1_resp_count", seen_resp, 1);
    chk("s1_strt_count", seen_strt, 1);
    chk("s1_moving_cycles", seen_mov, 0);

    // Plain move, 2 squares, long quiet sensor so speed saturates.
    clear_seen();
    error = 12'd10;
    hr_pct = 50;
    issue(16'h2002);
    repeat (400) step();
    ir_en = 1;
    run_done("move", 3000);
    chk("s2_peak_spd", peak_spd, 672);
    chk("s2_fan_count", seen_fan, 0);
    chk("s2_dh", desired_heading, 12'h000);
    chk("s2_resp_count", seen_resp, 1);

    // Fanfare move with large error first; a second command waits during the move.
    clear_seen();
    error = 12'h400;
    issue(16'h37F1);
    step();
    cmd = 16'h9001;
    cmd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      error = errs[i % 4];
      step();
    end
    chk("s3_no_speed_in_turn", peak_spd, 0);
    error = 12'd47;
    run_done("fanfare", 3000);
    chk("s3_dh", desired_heading, 12'h7FF);
    chk("s3_fan_count", seen_fan, 1);
    chk("s3_resp_count", seen_resp, 2);

    // Zero squares: turn only.
    clear_seen();
    error = 12'hFD1;
    issue(16'h2BF0);
    run_done("turn_only", 200);
    chk("s4_resp_count", seen_resp, 1);
    chk("s4_peak_spd", peak_spd, 0);
    chk("s4_dh", desired_heading, 12'hBFF);

    // Illegal opcode.
    clear_seen();
    issue(16'h9001);
    run_done("illegal", 50);
    chk("s5_resp_count", seen_resp, 1);
    chk("s5_moving_cycles", seen_mov, 0);

    // Reset during ramp up at speed 0x100.
    clear_seen();
    ir_en = 0;
    hr_pct = 100;
    error = 12'd0;
    issue(16'h2003);
    for (int i = 0; i < 200 && m_spd != 256; i++) step();
    chk("s6_reached_0x100", frwrd_spd, 10'h100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("s6_rst_spd", frwrd_spd, 10'd0);
    chk("s6_rst_moving", moving, 1'b0);
    chk("s6_rst_dh", desired_heading, 12'h000);
    chk("s6_rst_no_resp", seen_resp, 0);
    issue(16'h2000);
    run_done("after_rst", 100);
    chk("s6_resp_after", seen_resp, 1);

    // Random commands.
    ir_en = 1;
    err_rand = 1;
    cal_pct = 5;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(3))
        0: op = 0;
        1: op = 2;
        2: op = 3;
        default: op = $urandom_range(15);
      endcase
      hr_pct = $urandom_range(100, 30);
      issue({4'(op), 8'($urandom), 4'($urandom_range(3))});
      run_done("random", 5000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
